// File: rtl/fastpath_weight_train_if.sv
// rtl/fastpath_weight_train_if.sv - prediction read and training update bus for the weight table
interface fastpath_weight_train_if #(
  parameter int WEIGHT_NUM   = 33,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IDX_WIDTH    = 6
);
  logic [IDX_WIDTH-1:0]               rd_idx;
  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] rd_w;
  logic                               upd_valid;
  logic                               upd_ready;
  logic                               upd_taken;
  logic                               upd_pred;
  logic [WEIGHT_WIDTH-1:0]            upd_sum;
  logic [WEIGHT_NUM*IDX_WIDTH-1:0]    upd_path;
  logic                               upd_done;
  logic                               upd_trained;

  modport master (
    output rd_idx, upd_valid, upd_taken, upd_pred, upd_sum, upd_path,
    input  rd_w, upd_ready, upd_done, upd_trained
  );

  modport slave (
    input  rd_idx, upd_valid, upd_taken, upd_pred, upd_sum, upd_path,
    output rd_w, upd_ready, upd_done, upd_trained
  );
endinterface

// File: rtl/fastpath_weight_train.sv
// rtl/fastpath_weight_train.sv - perceptron weight table with registered row read and path-indexed training
module fastpath_weight_train #(
  parameter int WEIGHT_NUM       = 33,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int WEIGHT_ENTRY_NUM = 64,
  parameter int IDX_WIDTH        = 6,
  parameter int THETA            = 75
) (
  input logic                    clk,
  input logic                    rst,
  fastpath_weight_train_if.slave bus
);
  localparam int CNT_WIDTH = (WEIGHT_NUM > 1) ? $clog2(WEIGHT_NUM) : 1;
  localparam logic [WEIGHT_WIDTH-1:0] W_MAX     = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam logic [WEIGHT_WIDTH-1:0] W_MIN     = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
  localparam logic [WEIGHT_WIDTH:0]   THETA_MAG = (WEIGHT_WIDTH+1)'(THETA);
  localparam logic [CNT_WIDTH-1:0]    CNT_LAST  = CNT_WIDTH'(WEIGHT_NUM-1);

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE} state_t;

  state_t                             state;
  state_t                             state_next;
  logic [WEIGHT_WIDTH-1:0]            w_mem [WEIGHT_ENTRY_NUM][WEIGHT_NUM];
  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] rd_q;
  logic                               taken_q;
  logic                               pred_q;
  logic [WEIGHT_WIDTH-1:0]            sum_q;
  logic [WEIGHT_NUM*IDX_WIDTH-1:0]    path_q;
  logic [CNT_WIDTH-1:0]               cnt;
  logic [IDX_WIDTH-1:0]               path_col [WEIGHT_NUM];
  logic [WEIGHT_WIDTH:0]              sum_ext;
  logic [WEIGHT_WIDTH:0]              mag;
  logic                               accept;
  logic                               train;
  logic                               last_col;
  logic [IDX_WIDTH-1:0]               wr_row;
  logic [WEIGHT_WIDTH-1:0]            wr_old;
  logic [WEIGHT_WIDTH-1:0]            wr_new;
  logic                               ready_o;
  logic                               done_o;
  logic                               trained_o;

  // Split the captured path into one row index per column
  for (genvar c = 0; c < WEIGHT_NUM; c++) begin : g_path
    assign path_col[c] = path_q[c*IDX_WIDTH +: IDX_WIDTH];
  end

  // Magnitude is one bit wider than the sum so that the most negative sum stays positive
  assign sum_ext  = {sum_q[WEIGHT_WIDTH-1], sum_q};
  assign mag      = sum_ext[WEIGHT_WIDTH] ? (~sum_ext + (WEIGHT_WIDTH+1)'(1)) : sum_ext;
  assign train    = (pred_q != taken_q) || (mag <= THETA_MAG);
  assign accept   = (state == IDLE) && bus.upd_valid;
  assign last_col = (cnt == CNT_LAST);
  assign wr_row   = path_col[cnt];
  assign wr_old   = w_mem[wr_row][cnt];

  // Saturating +/-1 on the weight selected by the current column
  always_comb begin
    wr_new = wr_old;
    if (taken_q && (wr_old != W_MAX)) begin
      wr_new = wr_old + WEIGHT_WIDTH'(1);
    end else if (!taken_q && (wr_old != W_MIN)) begin
      wr_new = wr_old - WEIGHT_WIDTH'(1);
    end
  end

  // Weight table: cleared on reset, one column written per UPDATE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WEIGHT_ENTRY_NUM; r++) begin
        for (int c = 0; c < WEIGHT_NUM; c++) begin
          w_mem[r][c] <= '0;
        end
      end
    end else if (state == UPDATE) begin
      w_mem[wr_row][cnt] <= wr_new;
    end
  end

  // Registered row read; a same-edge write is not forwarded, so the old value is returned
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      for (int c = 0; c < WEIGHT_NUM; c++) begin
        rd_q[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= w_mem[bus.rd_idx][c];
      end
    end
  end

  // Holding registers keep the accepted request stable for the whole update
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q <= 1'b0;
      pred_q  <= 1'b0;
      sum_q   <= '0;
      path_q  <= '0;
    end else if (accept) begin
      taken_q <= bus.upd_taken;
      pred_q  <= bus.upd_pred;
      sum_q   <= bus.upd_sum;
      path_q  <= bus.upd_path;
    end
  end

  // Column counter walks 0..WEIGHT_NUM-1 during UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == CHECK) begin
      cnt <= '0;
    end else if ((state == UPDATE) && !last_col) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CHECK;
      CHECK:   state_next = train ? UPDATE : IDLE;
      UPDATE:  if (last_col) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE, done pulse at the end of either path
  always_comb begin
    ready_o   = (state == IDLE);
    done_o    = ((state == CHECK) && !train) || ((state == UPDATE) && last_col);
    trained_o = (state == UPDATE) && last_col;
  end

  assign bus.rd_w        = rd_q;
  assign bus.upd_ready   = ready_o;
  assign bus.upd_done    = done_o;
  assign bus.upd_trained = trained_o;
endmodule

// File: tb/tb_fastpath_weight_train.sv
// tb/tb_fastpath_weight_train.sv - scoreboard bench for the perceptron weight table
module tb_fastpath_weight_train;
  localparam int WN = 33;
  localparam int WW = 8;
  localparam int NE = 64;
  localparam int IW = 6;
  localparam int TH = 75;

  typedef struct {
    bit trained;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   stray = 0;
  exp_t exp_q[$];
  int   mdl [NE][WN];
  logic [IW-1:0] path_a [WN];

  always #5 clk = ~clk;

  fastpath_weight_train_if #(.WEIGHT_NUM(WN), .WEIGHT_WIDTH(WW), .IDX_WIDTH(IW)) bus ();

  fastpath_weight_train #(
    .WEIGHT_NUM(WN), .WEIGHT_WIDTH(WW), .WEIGHT_ENTRY_NUM(NE), .IDX_WIDTH(IW), .THETA(TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.upd_trained === 1'b1 && bus.upd_done !== 1'b1) stray++;
  end

  function automatic bit model_train(input bit taken, input bit pred, input int sum);
    int mag;
    mag = (sum < 0) ? -sum : sum;
    return (taken != pred) || (mag <= TH);
  endfunction

  task automatic apply_model(input bit taken);
    for (int c = 0; c < WN; c++) begin
      if (taken && mdl[path_a[c]][c] < 127) mdl[path_a[c]][c]++;
      else if (!taken && mdl[path_a[c]][c] > -128) mdl[path_a[c]][c]--;
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < NE; r++)
      for (int c = 0; c < WN; c++) mdl[r][c] = 0;
  endtask

  task automatic set_path(input int prow);
    for (int c = 0; c < WN; c++)
      path_a[c] = (prow >= 0) ? IW'(prow) : IW'($urandom_range(0, NE-1));
  endtask

  task automatic drive_inputs(input bit taken, input bit pred, input int sum);
    bus.upd_taken = taken;
    bus.upd_pred  = pred;
    bus.upd_sum   = WW'(sum);
    for (int c = 0; c < WN; c++) bus.upd_path[c*IW +: IW] = path_a[c];
  endtask

  task automatic check_all_rows(input string name);
    logic [WN*WW-1:0] expv;
    for (int i = 0; i <= NE; i++) begin
      @(negedge clk);
      if (i > 0) begin
        for (int c = 0; c < WN; c++) expv[c*WW +: WW] = WW'(mdl[i-1][c]);
        tests_run++;
        if (bus.rd_w !== expv) begin
          tests_failed++;
          $display("FAIL %s row %0d: got %h want %h", name, i-1, bus.rd_w, expv);
        end
      end
      if (i < NE) bus.rd_idx = IW'(i);
    end
  endtask

  task automatic do_update(input bit taken, input bit pred, input int sum, input int prow, input string name);
    bit   tr;
    bit   seen;
    int   cyc;
    exp_t e;
    set_path(prow);
    @(negedge clk);
    tests_run++;
    if (bus.upd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before: got %b want 1", name, bus.upd_ready);
    end
    drive_inputs(taken, pred, sum);
    bus.upd_valid = 1'b1;
    tr = model_train(taken, pred, sum);
    exp_q.push_back('{tr, tr ? 1 + WN : 1});
    @(negedge clk);
    bus.upd_valid = 1'b0;
    bus.upd_taken = ~taken;
    bus.upd_pred  = ~pred;
    bus.upd_sum   = WW'(-sum);
    bus.upd_path  = '1;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      if (bus.upd_done === 1'b1) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        tests_run++;
        if (bus.upd_trained !== e.trained || cyc != e.done_cyc) begin
          tests_failed++;
          $display("FAIL %s done: got trained=%b cyc=%0d want trained=%b cyc=%0d",
                   name, bus.upd_trained, cyc, e.trained, e.done_cyc);
        end
        if (tr) apply_model(taken);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: got no upd_done want upd_done", name);
      exp_q.delete();
    end
    @(negedge clk);
    tests_run++;
    if (bus.upd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_after: got %b want 1", name, bus.upd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.upd_valid = 1'b0;
    bus.rd_idx = '0;
    drive_inputs(1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    tests_run++;
    if (bus.upd_ready !== 1'b1 || bus.upd_done !== 1'b0 || bus.upd_trained !== 1'b0 || bus.rd_w !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b done=%b trained=%b rd_w=%h want 1 0 0 0",
               bus.upd_ready, bus.upd_done, bus.upd_trained, bus.rd_w);
    end
    check_all_rows("reset_sweep");
  endtask

  task automatic test_mispredict();
    do_update(1'b1, 1'b0, -5, 7, "mispredict");
    check_all_rows("mispredict_rows");
  endtask

  task automatic test_confident();
    do_update(1'b1, 1'b1, 100, -1, "confident");
    check_all_rows("confident_rows");
  endtask

  task automatic test_threshold();
    do_update(1'b0, 1'b0, 75, -1, "thr_75");
    do_update(1'b1, 1'b1, 76, -1, "thr_76");
    do_update(1'b0, 1'b0, -128, -1, "thr_m128");
    do_update(1'b1, 1'b1, -75, -1, "thr_m75");
    check_all_rows("threshold_rows");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 130; i++) do_update(1'b1, 1'b0, 0, 3, "sat_up");
    check_all_rows("sat_up_rows");
    for (int i = 0; i < 300; i++) do_update(1'b0, 1'b1, 0, 3, "sat_down");
    check_all_rows("sat_down_rows");
  endtask

  task automatic test_back_to_back();
    int   ready_hi;
    exp_t e;
    set_path(-1);
    @(negedge clk);
    drive_inputs(1'b0, 1'b1, 0);
    bus.upd_valid = 1'b1;
    exp_q.push_back('{1'b1, 1 + WN});
    exp_q.push_back('{1'b1, 2 + 2*WN + 1});
    ready_hi = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 36) bus.upd_valid = 1'b0;
      if (cyc <= 1 + WN && bus.upd_ready === 1'b1) ready_hi++;
      if (cyc == 2 + WN) begin
        tests_run++;
        if (bus.upd_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_ready_reopen: got %b want 1", bus.upd_ready);
        end
      end
      if (bus.upd_done === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_done: got unexpected done at cyc %0d want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.upd_trained !== e.trained || cyc != e.done_cyc) begin
            tests_failed++;
            $display("FAIL b2b_done: got trained=%b cyc=%0d want trained=%b cyc=%0d",
                     bus.upd_trained, cyc, e.trained, e.done_cyc);
          end
        end
      end
    end
    tests_run++;
    if (ready_hi != 0) begin
      tests_failed++;
      $display("FAIL b2b_backpressure: got %0d ready cycles want 0", ready_hi);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_pending: got %0d outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    apply_model(1'b0);
    apply_model(1'b0);
    check_all_rows("b2b_rows");
  endtask

  task automatic test_reset_midflight();
    int dones;
    set_path(-1);
    @(negedge clk);
    drive_inputs(1'b1, 1'b0, 0);
    bus.upd_valid = 1'b1;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (bus.upd_done === 1'b1) dones++;
      @(negedge clk);
    end
    rst = 1'b1;
    bus.upd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.upd_valid = 1'b0;
    tests_run++;
    if (bus.upd_ready !== 1'b1 || bus.upd_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: got ready=%b done=%b want 1 0", bus.upd_ready, bus.upd_done);
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.upd_done === 1'b1) dones++;
      @(negedge clk);
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL midreset_done: got %0d pulses want 0", dones);
    end
    clear_model();
    check_all_rows("midreset_rows");
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_confident();
    test_threshold();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL trained_qualify: got %0d stray cycles want 0", stray);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
